// File: rtl/atm_pkg.sv
// Definitions shared between the keypad front end and the ATM core:
// the core's command encoding, the special keypad keys and the front-end states.
package atm_pkg;

    typedef enum logic [2:0] {
        CTRL_IDLE         = 3'd0,
        CTRL_SHOWBALANCE  = 3'd2,
        CTRL_WITHDRAW     = 3'd3,
        CTRL_WITHDRAWSHOW = 3'd4,
        CTRL_TRANSFER     = 3'd5,
        CTRL_DEPOSIT      = 3'd6
    } control_t;

    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        S_ID,
        S_PASS,
        S_CMD,
        S_AMT,
        S_DEST,
        S_ISSUE
    } fe_state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // Codes above Cancel have no meaning on the keypad.
    function automatic logic is_invalid_key(input logic [3:0] key);
        return key > KEY_CANCEL;
    endfunction

endpackage

// File: rtl/decimal_entry_accumulator.sv
// Builds a decimal number one key at a time; digits past MAX_DIGITS are dropped
// and the caller is told via too_many so it can flag the rejected key.
module decimal_entry_accumulator #(
    parameter int MAX_DIGITS = 3,
    localparam int COUNT_W = $clog2(MAX_DIGITS + 1)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               digit_valid,
    input  logic [3:0]         digit,
    input  logic               clear,
    input  logic               load,
    output logic [7:0]         value,
    output logic [COUNT_W-1:0] count,
    output logic               too_many,
    output logic               overflow
);

    logic [9:0] acc;

    // Clear and load both restart the field; load marks that the value was taken.
    always_ff @(posedge Clock) begin
        if (Reset || clear || load) begin
            acc   <= '0;
            count <= '0;
        end else if (digit_valid && !too_many) begin
            acc   <= acc * 10'd10 + {6'd0, digit};
            count <= count + COUNT_W'(1);
        end
    end

    assign too_many = (count >= COUNT_W'(MAX_DIGITS));
    assign overflow = (acc > 10'd255);
    assign value    = acc[7:0];

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad front end for the ATM core: collects ID, password, command and operands,
// then offers the command on a valid/ready handshake; ejects on cancel or idle timeout.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_DIGITS     = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       KeyValid,
    input  logic [3:0] KeyCode,
    input  logic       CmdReady,
    output logic [7:0] ID,
    output logic [7:0] Password,
    output logic [2:0] Control,
    output logic [7:0] Request,
    output logic [7:0] DestID,
    output logic       CmdValid,
    output logic       Eject,
    output logic       EntryErr
);

    localparam int COUNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    fe_state_t          state, state_next;
    control_t           control_q, control_next;
    control_t           pending_q, pending_next;
    logic [7:0]         id_q, id_next;
    logic [7:0]         pass_q, pass_next;
    logic [7:0]         req_q, req_next;
    logic [7:0]         dest_q, dest_next;
    logic               cmd_valid_q, cmd_valid_next;
    logic               eject_q, eject_next;
    logic               err_q, err_next;
    logic [TIMER_W-1:0] timer_q, timer_next;

    logic               acc_digit, acc_clear, acc_load;
    logic [7:0]         acc_value;
    logic [COUNT_W-1:0] digit_count;
    logic               acc_too_many, acc_overflow;

    logic handshake, timer_frozen, timeout, cancel;

    decimal_entry_accumulator #(
        .MAX_DIGITS(MAX_DIGITS)
    ) u_acc (
        .Clock      (Clock),
        .Reset      (Reset),
        .digit_valid(acc_digit),
        .digit      (KeyCode),
        .clear      (acc_clear),
        .load       (acc_load),
        .value      (acc_value),
        .count      (digit_count),
        .too_many   (acc_too_many),
        .overflow   (acc_overflow)
    );

    // A completing handshake wins over a Cancel arriving in the same cycle.
    assign handshake    = (state == S_ISSUE) && cmd_valid_q && CmdReady;
    assign timer_frozen = (state == S_ISSUE) || ((state == S_ID) && (digit_count == '0));
    assign timeout      = !KeyValid && !timer_frozen && (timer_q == TIMER_LAST);
    assign cancel       = (KeyValid && (KeyCode == KEY_CANCEL) && !handshake) || timeout;

    always_comb begin
        state_next     = state;
        id_next        = id_q;
        pass_next      = pass_q;
        req_next       = req_q;
        dest_next      = dest_q;
        control_next   = control_q;
        pending_next   = pending_q;
        cmd_valid_next = cmd_valid_q;
        eject_next     = 1'b0;
        err_next       = 1'b0;
        acc_digit      = 1'b0;
        acc_clear      = 1'b0;
        acc_load       = 1'b0;

        if (cancel) begin
            state_next     = S_ID;
            id_next        = '0;
            pass_next      = '0;
            req_next       = '0;
            dest_next      = '0;
            control_next   = CTRL_IDLE;
            pending_next   = CTRL_IDLE;
            cmd_valid_next = 1'b0;
            eject_next     = 1'b1;
            acc_clear      = 1'b1;
        end else if (handshake) begin
            state_next     = S_CMD;
            control_next   = CTRL_IDLE;
            cmd_valid_next = 1'b0;
            err_next       = KeyValid && is_invalid_key(KeyCode);
        end else if (KeyValid) begin
            if (is_invalid_key(KeyCode)) begin
                err_next = 1'b1;
            end else begin
                case (state)
                    S_ID, S_PASS, S_AMT, S_DEST: begin
                        if (is_digit(KeyCode)) begin
                            acc_digit = 1'b1;
                            err_next  = acc_too_many;
                        end else if (KeyCode == KEY_CLEAR) begin
                            acc_clear = 1'b1;
                        end else if ((digit_count == '0) || acc_overflow) begin
                            err_next  = 1'b1;
                            acc_clear = 1'b1;
                        end else begin
                            // Only Enter reaches here: the field is accepted.
                            acc_load = 1'b1;
                            case (state)
                                S_ID: begin
                                    id_next    = acc_value;
                                    state_next = S_PASS;
                                end
                                S_PASS: begin
                                    pass_next  = acc_value;
                                    state_next = S_CMD;
                                end
                                S_DEST: begin
                                    dest_next  = acc_value;
                                    state_next = S_AMT;
                                end
                                default: begin
                                    req_next       = acc_value;
                                    control_next   = pending_q;
                                    cmd_valid_next = 1'b1;
                                    state_next     = S_ISSUE;
                                end
                            endcase
                        end
                    end
                    S_CMD: begin
                        case (KeyCode)
                            4'd2: begin
                                control_next   = CTRL_SHOWBALANCE;
                                cmd_valid_next = 1'b1;
                                state_next     = S_ISSUE;
                            end
                            4'd3: begin
                                pending_next = CTRL_WITHDRAW;
                                state_next   = S_AMT;
                            end
                            4'd4: begin
                                pending_next = CTRL_WITHDRAWSHOW;
                                state_next   = S_AMT;
                            end
                            4'd6: begin
                                pending_next = CTRL_DEPOSIT;
                                state_next   = S_AMT;
                            end
                            4'd5: begin
                                pending_next = CTRL_TRANSFER;
                                state_next   = S_DEST;
                            end
                            default: err_next = 1'b1;
                        endcase
                    end
                    default: ;
                endcase
            end
        end

        if (cancel || KeyValid) begin
            timer_next = '0;
        end else if (timer_frozen) begin
            timer_next = timer_q;
        end else begin
            timer_next = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_ID;
            id_q        <= '0;
            pass_q      <= '0;
            req_q       <= '0;
            dest_q      <= '0;
            control_q   <= CTRL_IDLE;
            pending_q   <= CTRL_IDLE;
            cmd_valid_q <= 1'b0;
            eject_q     <= 1'b0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state       <= state_next;
            id_q        <= id_next;
            pass_q      <= pass_next;
            req_q       <= req_next;
            dest_q      <= dest_next;
            control_q   <= control_next;
            pending_q   <= pending_next;
            cmd_valid_q <= cmd_valid_next;
            eject_q     <= eject_next;
            err_q       <= err_next;
            timer_q     <= timer_next;
        end
    end

    assign ID       = id_q;
    assign Password = pass_q;
    assign Control  = control_q;
    assign Request  = req_q;
    assign DestID   = dest_q;
    assign CmdValid = cmd_valid_q;
    assign Eject    = eject_q;
    assign EntryErr = err_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench for atm_keypad_frontend: key sequences push expected commands,
// ejects and entry errors; a negedge monitor pops them as the DUT produces them.
module tb_atm_keypad_frontend;

    localparam int EV_CMD   = 0;
    localparam int EV_EJECT = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int kind;
        int ctrl;
        int id;
        int pass;
        int req;
        int dest;
        int cyc;
    } ev_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       KeyValid;
    logic [3:0] KeyCode;
    logic       CmdReady;
    logic [7:0] ID, Password, Request, DestID;
    logic [2:0] Control;
    logic       CmdValid, Eject, EntryErr;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   last_key_cycle = 0;
    ev_t  sb[$];
    ev_t  cur_cmd;
    logic cv_prev = 1'b0;

    atm_keypad_frontend #(
        .TIMEOUT_CYCLES(8),
        .MAX_DIGITS    (3)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .KeyValid(KeyValid),
        .KeyCode (KeyCode),
        .CmdReady(CmdReady),
        .ID      (ID),
        .Password(Password),
        .Control (Control),
        .Request (Request),
        .DestID  (DestID),
        .CmdValid(CmdValid),
        .Eject   (Eject),
        .EntryErr(EntryErr)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectCmd(input int ctrl, input int id, input int pass, input int req, input int dest);
        ev_t e;
        e = '{kind: EV_CMD, ctrl: ctrl, id: id, pass: pass, req: req, dest: dest, cyc: -1};
        sb.push_back(e);
    endtask

    task automatic expectEvent(input int kind, input int cyc);
        ev_t e;
        e = '{kind: kind, ctrl: 0, id: 0, pass: 0, req: 0, dest: 0, cyc: cyc};
        sb.push_back(e);
    endtask

    task automatic popEvent(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected event: got kind %0d at cycle %0d, expected none", kind, cycle);
            return;
        end
        e = sb.pop_front();
        checkOutput("event kind", kind, e.kind);
        if ((kind == e.kind) && (kind != EV_ERR)) begin
            checkOutput("Control", Control, e.ctrl);
            checkOutput("ID", ID, e.id);
            checkOutput("Password", Password, e.pass);
            checkOutput("Request", Request, e.req);
            checkOutput("DestID", DestID, e.dest);
            checkOutput("CmdValid", CmdValid, (kind == EV_CMD) ? 1 : 0);
            if (e.cyc >= 0) checkOutput("event cycle", cycle, e.cyc);
            if (kind == EV_CMD) cur_cmd = e;
        end
    endtask

    // Monitor: one event per output pulse; operands must hold while a command waits.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (EntryErr) popEvent(EV_ERR);
            if (Eject) popEvent(EV_EJECT);
            if (CmdValid && !cv_prev) begin
                popEvent(EV_CMD);
            end else if (CmdValid) begin
                checkOutput("held Control", Control, cur_cmd.ctrl);
                checkOutput("held ID", ID, cur_cmd.id);
                checkOutput("held Password", Password, cur_cmd.pass);
                checkOutput("held Request", Request, cur_cmd.req);
                checkOutput("held DestID", DestID, cur_cmd.dest);
            end
        end
        cv_prev = CmdValid;
    end

    task automatic applyStimulus(input logic [3:0] code);
        @(negedge Clock);
        KeyValid = 1'b1;
        KeyCode  = code;
        @(posedge Clock);
        #1;
        KeyValid = 1'b0;
        last_key_cycle = cycle;
    endtask

    // Keys as hex characters: 0-9 digits, A Enter, B Clear, C Cancel, D-F invalid.
    task automatic applyKeys(input string keys);
        byte c;
        for (int i = 0; i < keys.len(); i++) begin
            c = keys[i];
            if (c >= 8'h41) applyStimulus(4'(c - 8'h37));
            else applyStimulus(4'(c - 8'h30));
        end
    endtask

    task automatic waitCmdValid();
        int n;
        n = 0;
        while (!CmdValid && (n < 20)) begin
            @(negedge Clock);
            n++;
        end
        checkOutput("CmdValid presented", CmdValid, 1);
    endtask

    task automatic doHandshake();
        waitCmdValid();
        @(negedge Clock);
        CmdReady = 1'b1;
        @(posedge Clock);
        #1;
        CmdReady = 1'b0;
        @(negedge Clock);
        checkOutput("CmdValid after accept", CmdValid, 0);
        checkOutput("Control after accept", Control, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ID"}, ID, 0);
        checkOutput({tag, " Password"}, Password, 0);
        checkOutput({tag, " Control"}, Control, 0);
        checkOutput({tag, " Request"}, Request, 0);
        checkOutput({tag, " DestID"}, DestID, 0);
        checkOutput({tag, " CmdValid"}, CmdValid, 0);
    endtask

    initial begin
        Reset    = 1'b1;
        KeyValid = 1'b0;
        KeyCode  = 4'd0;
        CmdReady = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        checkAllZero("reset");
        checkOutput("reset Eject", Eject, 0);
        checkOutput("reset EntryErr", EntryErr, 0);

        $display("[TB] session login and show balance");
        expectCmd(2, 123, 42, 0, 0);
        applyKeys("123A042A2");
        doHandshake();
        checkOutput("Request kept", Request, 0);

        $display("[TB] transfer held for ten cycles");
        expectCmd(5, 123, 42, 50, 7);
        applyKeys("57A50A");
        waitCmdValid();
        repeat (10) @(negedge Clock);
        doHandshake();
        checkOutput("Request kept after transfer", Request, 50);
        checkOutput("DestID kept after transfer", DestID, 7);

        $display("[TB] withdraw with a dropped fourth digit");
        expectEvent(EV_ERR, -1);
        expectCmd(3, 123, 42, 123, 7);
        applyKeys("31234A");
        doHandshake();

        $display("[TB] deposit with empty and overflowing amounts");
        expectEvent(EV_ERR, -1);
        expectEvent(EV_ERR, -1);
        expectCmd(6, 123, 42, 10, 7);
        applyKeys("6A999A10A");
        doHandshake();

        $display("[TB] rejected keys in command state");
        expectEvent(EV_ERR, -1);
        expectEvent(EV_ERR, -1);
        expectEvent(EV_ERR, -1);
        applyKeys("E1A");

        $display("[TB] cancel while a command waits");
        expectCmd(2, 123, 42, 10, 7);
        applyKeys("2");
        waitCmdValid();
        expectEvent(EV_EJECT, -1);
        applyStimulus(4'hC);
        @(negedge Clock);
        checkAllZero("cancel");

        $display("[TB] ID range check");
        expectEvent(EV_ERR, -1);
        applyKeys("300A");
        checkOutput("ID after rejected Enter", ID, 0);
        expectCmd(2, 255, 9, 0, 0);
        applyKeys("255A9A2");
        waitCmdValid();
        @(negedge Clock);
        KeyValid = 1'b1;
        KeyCode  = 4'hC;
        CmdReady = 1'b1;
        @(posedge Clock);
        #1;
        KeyValid = 1'b0;
        CmdReady = 1'b0;
        @(negedge Clock);
        checkOutput("cancel+ready CmdValid", CmdValid, 0);
        checkOutput("cancel+ready Control", Control, 0);
        checkOutput("cancel+ready Eject", Eject, 0);
        checkOutput("cancel+ready ID", ID, 255);

        $display("[TB] inactivity timeout");
        expectEvent(EV_EJECT, -1);
        applyKeys("C1A");
        expectEvent(EV_EJECT, last_key_cycle + 8);
        for (int n = 0; (n < 40) && (sb.size() != 0); n++) @(negedge Clock);

        $display("[TB] reset during amount entry");
        applyKeys("1A2A345");
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkAllZero("mid reset");
        expectCmd(2, 7, 8, 0, 0);
        applyKeys("7A8A2");
        doHandshake();

        repeat (2) @(negedge Clock);
        while (sb.size() != 0) begin
            ev_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing event: got none, expected kind %0d", e.kind);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
